// File: rtl/grid_neighbor_mem_if.sv
// Bus bundle for grid_neighbor_mem: clear control, 3x3 neighbourhood read port,
// single-cell read port and single-cell write port.
interface grid_neighbor_mem_if #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10,
    parameter int CELL_W = 8,
    parameter int RC_W   = 4
);
    logic                  clr_req;
    logic                  busy;
    logic                  nb_req;
    logic [RC_W-1:0]       nb_row;
    logic [RC_W-1:0]       nb_col;
    logic                  nb_valid;
    logic [9*CELL_W-1:0]   nb_data;
    logic                  rd_en;
    logic [RC_W-1:0]       rd_row;
    logic [RC_W-1:0]       rd_col;
    logic                  rd_valid;
    logic [CELL_W-1:0]     rd_data;
    logic                  wr_en;
    logic [RC_W-1:0]       wr_row;
    logic [RC_W-1:0]       wr_col;
    logic [CELL_W-1:0]     wr_data;

    modport master (
        output clr_req, nb_req, nb_row, nb_col, rd_en, rd_row, rd_col,
               wr_en, wr_row, wr_col, wr_data,
        input  busy, nb_valid, nb_data, rd_valid, rd_data
    );

    modport slave (
        input  clr_req, nb_req, nb_row, nb_col, rd_en, rd_row, rd_col,
               wr_en, wr_row, wr_col, wr_data,
        output busy, nb_valid, nb_data, rd_valid, rd_data
    );
endinterface

// File: rtl/grid_neighbor_mem.sv
// GRID_H x GRID_W cell memory with a registered 3x3 neighbourhood port, a cell
// read/write port and a clear sweep. Define GRID_WRAP_EN for toroidal edges.
module grid_neighbor_mem #(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10,
    parameter int CELL_W = 8,
    parameter int RC_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    grid_neighbor_mem_if.slave bus
);
    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int IDX_W   = $clog2(N_CELLS);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [IDX_W-1:0]    r_clr_cnt, w_clr_cnt_next;
    logic [CELL_W-1:0]   r_mem [N_CELLS];

    logic                w_idle;
    logic                w_wr_ok;
    logic [IDX_W-1:0]    w_wr_idx;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_mem_idx;
    logic [CELL_W-1:0]   w_mem_din;
    logic [9*CELL_W-1:0] w_nb_flat;
    logic [CELL_W-1:0]   w_rd_cell;

    logic                r_nb_valid;
    logic [9*CELL_W-1:0] r_nb_data;
    logic                r_rd_valid;
    logic [CELL_W-1:0]   r_rd_data;

    function automatic logic in_grid(input int row, input int col);
        return (row >= 0) && (row < GRID_H) && (col >= 0) && (col < GRID_W);
    endfunction

    function automatic int lin(input int row, input int col);
        return row * GRID_W + col;
    endfunction

    // Cell at (row+dr, col+dc) relative to an in-grid centre, with the
    // same-cycle write forwarded so reads behave write-first.
    function automatic logic [CELL_W-1:0] fetch(input int row, input int col,
                                                input int dr, input int dc);
        int rr;
        int cc;
        logic [CELL_W-1:0] v;
        v  = '0;
        rr = row + dr;
        cc = col + dc;
`ifdef GRID_WRAP_EN
        if (rr < 0) rr = GRID_H - 1; else if (rr >= GRID_H) rr = 0;
        if (cc < 0) cc = GRID_W - 1; else if (cc >= GRID_W) cc = 0;
`endif
        if (in_grid(row, col) && in_grid(rr, cc)) begin
            if (w_wr_ok && (w_wr_idx == IDX_W'(lin(rr, cc))))
                v = bus.wr_data;
            else
                v = r_mem[IDX_W'(lin(rr, cc))];
        end
        return v;
    endfunction

    assign w_idle   = (r_state == S_IDLE);
    assign w_wr_ok  = w_idle && bus.wr_en && !bus.clr_req
                      && in_grid(int'(bus.wr_row), int'(bus.wr_col));
    assign w_wr_idx = IDX_W'(lin(int'(bus.wr_row), int'(bus.wr_col)));

    // NW lands in the MSBs, SE in the LSBs.
    for (genvar gi = 0; gi < 9; gi++) begin : g_nb
        assign w_nb_flat[(8-gi)*CELL_W +: CELL_W] =
            fetch(int'(bus.nb_row), int'(bus.nb_col), gi / 3 - 1, gi % 3 - 1);
    end

    assign w_rd_cell = fetch(int'(bus.rd_row), int'(bus.rd_col), 0, 0);

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_mem_we       = 1'b0;
        w_mem_idx      = w_wr_idx;
        w_mem_din      = bus.wr_data;
        case (r_state)
            S_IDLE: begin
                w_mem_we = w_wr_ok;
                if (bus.clr_req) begin
                    w_state_next   = S_CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            S_CLEAR: begin
                w_mem_we       = 1'b1;
                w_mem_idx      = r_clr_cnt;
                w_mem_din      = '0;
                w_clr_cnt_next = r_clr_cnt + IDX_W'(1);
                if (r_clr_cnt == IDX_W'(N_CELLS - 1)) begin
                    w_state_next   = S_IDLE;
                    w_clr_cnt_next = '0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Storage has no reset; the sweep that follows reset zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_idx] <= w_mem_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nb_valid <= 1'b0;
            r_nb_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_nb_valid <= w_idle && bus.nb_req;
            r_rd_valid <= w_idle && bus.rd_en;
            if (w_idle && bus.nb_req)
                r_nb_data <= w_nb_flat;
            if (w_idle && bus.rd_en)
                r_rd_data <= w_rd_cell;
        end
    end

    assign bus.busy     = (r_state == S_CLEAR);
    assign bus.nb_valid = r_nb_valid;
    assign bus.nb_data  = r_nb_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
endmodule
